int_ctrl: RTL and testbench

Interrupt controller placed directly upstream of `cpu`, driving its four interrupt inputs `ie1`..`ie4`. It synchronises four asynchronous external request lines, detects rising edges, latches them as pending, and presents at most one masked, highest-priority request to the CPU at a time. Each request is held until the CPU acknowledges it, and no further request is issued until the CPU signals end-of-interrupt.

---
 rtl/int_ctrl_if.sv | 30 +++
 rtl/int_ctrl.sv | 147 ++++++++++++++
 tb/tb_int_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_if.sv
// int_ctrl_if -- bundle of request, mask, CPU handshake and status signals
// of the interrupt controller.
//   master : the CPU / system side (drives irq, mask_we/mask_din, ack, eoi)
//   slave  : the int_ctrl block (drives ie1..ie4, pending, mask,
//            in_service, isr_id)
interface int_ctrl_if;
  logic [3:0] irq;         // asynchronous external requests, bit 0 highest priority
  logic       mask_we;     // mask register write strobe
  logic [3:0] mask_din;    // new mask value
  logic       ack;         // CPU entered service routine (1-cycle pulse)
  logic       eoi;         // CPU left service routine (1-cycle pulse)
  logic       ie1;         // request to CPU for irq[0]
  logic       ie2;         // request to CPU for irq[1]
  logic       ie3;         // request to CPU for irq[2]
  logic       ie4;         // request to CPU for irq[3]
  logic [3:0] pending;     // pending-request register
  logic [3:0] mask;        // current mask register
  logic       in_service;  // a request is being serviced
  logic [1:0] isr_id;      // index of the request last issued

  modport master (
    output irq, mask_we, mask_din, ack, eoi,
    input  ie1, ie2, ie3, ie4, pending, mask, in_service, isr_id
  );

  modport slave (
    input  irq, mask_we, mask_din, ack, eoi,
    output ie1, ie2, ie3, ie4, pending, mask, in_service, isr_id
  );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl -- four-line interrupt controller feeding the CPU's ie1..ie4.
// Synchronises the asynchronous irq lines, turns rising edges into pending
// bits, and issues the lowest-index masked-in pending line to the CPU,
// one at a time, with an ack / eoi handshake.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : int_ctrl_if slave modport (irq, mask write, ack/eoi in;
//           ie1..ie4, pending, mask, in_service, isr_id out)
module int_ctrl #(
  parameter logic [3:0] MASK_RST = 4'b1111
) (
  input  logic       clk,
  input  logic       reset,
  int_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // Lowest set bit of a 4-bit vector wins (bit 0 is highest priority).
  function automatic logic [1:0] sel_lowest(input logic [3:0] v);
    logic [1:0] idx;
    casez (v)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Index to one-hot line vector.
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    logic [3:0] v;
    case (idx)
      2'd0:    v = 4'b0001;
      2'd1:    v = 4'b0010;
      2'd2:    v = 4'b0100;
      2'd3:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] s1_q, s2_q, s3_q;
  logic [3:0] pending_q, pending_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] ie_q, ie_d;
  logic [1:0] isr_id_q, isr_id_d;
  logic       in_service_q, in_service_d;

  logic [3:0] strobe_s;
  logic [3:0] eligible_s;
  logic [1:0] sel_s;
  logic [3:0] clr_s;

  assign strobe_s   = s2_q & ~s3_q;
  assign eligible_s = pending_q & mask_q;
  assign sel_s      = sel_lowest(eligible_s);

  // Next-state, issue and pending-update logic.
  always_comb begin
    state_d  = state_q;
    isr_id_d = isr_id_q;
    ie_d     = ie_q;
    clr_s    = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (eligible_s != 4'b0000) begin
          isr_id_d = sel_s;
          ie_d     = onehot(sel_s);
          state_d  = ST_REQ;
        end else begin
          ie_d     = 4'b0000;
        end
      end
      ST_REQ: begin
        // The issued request is held regardless of mask changes or newly
        // pending higher-priority lines until the CPU acknowledges it.
        if (bus.ack) begin
          clr_s   = onehot(isr_id_q);
          ie_d    = 4'b0000;
          state_d = ST_SERVICE;
        end else begin
          ie_d    = ie_q;
        end
      end
      ST_SERVICE: begin
        if (bus.eoi) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ie_d    = 4'b0000;
      end
    endcase

    // A set from an edge strobe overrides a same-cycle clear from ack.
    pending_d    = (pending_q & ~clr_s) | strobe_s;
    mask_d       = bus.mask_we ? bus.mask_din : mask_q;
    in_service_d = (state_d == ST_SERVICE);
  end

  // Registered state: synchroniser chain, pending, mask, FSM and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q         <= 4'b0000;
      s2_q         <= 4'b0000;
      s3_q         <= 4'b0000;
      pending_q    <= 4'b0000;
      mask_q       <= MASK_RST;
      ie_q         <= 4'b0000;
      isr_id_q     <= 2'd0;
      in_service_q <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      s1_q         <= bus.irq;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      ie_q         <= ie_d;
      isr_id_q     <= isr_id_d;
      in_service_q <= in_service_d;
      state_q      <= state_d;
    end
  end

  assign bus.ie1        = ie_q[0];
  assign bus.ie2        = ie_q[1];
  assign bus.ie3        = ie_q[2];
  assign bus.ie4        = ie_q[3];
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;
  assign bus.in_service = in_service_q;
  assign bus.isr_id     = isr_id_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl -- directed self-checking bench for int_ctrl.
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// half a period after the rising edge that updated them.
module tb_int_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  int_ctrl_if bus ();

  int_ctrl #(.MASK_RST(4'b1111)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ie_vec();
    return {bus.ie4, bus.ie3, bus.ie2, bus.ie1};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.eoi = 1'b1;
    step();
    bus.eoi = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.irq      = 4'b0000;
    bus.mask_we  = 1'b0;
    bus.mask_din = 4'b0000;
    bus.ack      = 1'b0;
    bus.eoi      = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_ie",      {4'h0, ie_vec()},        8'h00);
    chk("rst_pending", {4'h0, bus.pending},     8'h00);
    chk("rst_mask",    {4'h0, bus.mask},        8'h0f);
    chk("rst_insvc",   {7'h0, bus.in_service},  8'h00);
    chk("rst_isr_id",  {6'h0, bus.isr_id},      8'h00);

    // Single request on line 2: pending after edge k+2, ie3 after edge k+3
    bus.irq = 4'b0100;
    step(); step(); step();
    chk("single_pend_k2", {4'h0, bus.pending}, 8'h04);
    chk("single_ie_k2",   {4'h0, ie_vec()},    8'h00);
    step();
    chk("single_ie_k3",   {4'h0, ie_vec()},    8'h04);
    chk("single_id",      {6'h0, bus.isr_id},  8'h02);
    pulse_ack();
    chk("single_ack_ie",   {4'h0, ie_vec()},       8'h00);
    chk("single_ack_pend", {4'h0, bus.pending},    8'h00);
    chk("single_ack_svc",  {7'h0, bus.in_service}, 8'h01);
    // level held high must not re-request
    step(); step(); step(); step();
    chk("single_level_pend", {4'h0, bus.pending}, 8'h00);
    bus.irq = 4'b0000;
    pulse_eoi();
    chk("single_eoi_svc", {7'h0, bus.in_service}, 8'h00);
    chk("single_eoi_ie",  {4'h0, ie_vec()},       8'h00);

    // Priority: lines 3 and 1 together, line 1 first
    bus.irq = 4'b1010;
    step(); step(); step(); step();
    chk("prio_ie_first", {4'h0, ie_vec()},    8'h02);
    chk("prio_id_first", {6'h0, bus.isr_id},  8'h01);
    chk("prio_pend",     {4'h0, bus.pending}, 8'h0a);
    bus.irq = 4'b0000;
    pulse_ack();
    chk("prio_ack_pend", {4'h0, bus.pending}, 8'h08);
    chk("prio_svc_ie",   {4'h0, ie_vec()},    8'h00);
    step();
    chk("prio_hold_ie",  {4'h0, ie_vec()},    8'h00);
    pulse_eoi();
    chk("prio_eoi_ie",   {4'h0, ie_vec()},    8'h00);
    step();
    chk("prio_ie_second", {4'h0, ie_vec()},   8'h08);
    chk("prio_id_second", {6'h0, bus.isr_id}, 8'h03);
    pulse_ack();
    pulse_eoi();
    chk("prio_done_pend", {4'h0, bus.pending}, 8'h00);

    // Mask: masked line becomes pending but is not issued
    bus.mask_we  = 1'b1;
    bus.mask_din = 4'b1110;
    step();
    bus.mask_we  = 1'b0;
    chk("mask_val", {4'h0, bus.mask}, 8'h0e);
    bus.irq = 4'b0001;
    step(); step(); step();
    chk("mask_pend", {4'h0, bus.pending}, 8'h01);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("mask_no_ie", {4'h0, ie_vec()}, 8'h00);
    end
    bus.irq      = 4'b0000;
    bus.mask_we  = 1'b1;
    bus.mask_din = 4'b1111;
    step();
    bus.mask_we  = 1'b0;
    chk("unmask_ie_w",  {4'h0, ie_vec()},   8'h00);
    step();
    chk("unmask_ie",    {4'h0, ie_vec()},   8'h01);
    chk("unmask_id",    {6'h0, bus.isr_id}, 8'h00);
    pulse_ack();
    pulse_eoi();

    // Re-pend during service of line 1
    bus.irq = 4'b0010;
    step(); step(); step(); step();
    chk("rep_ie", {4'h0, ie_vec()}, 8'h02);
    bus.irq = 4'b0000;
    pulse_ack();
    step(); step();
    bus.irq = 4'b0010;
    step(); step(); step();
    chk("rep_pend", {4'h0, bus.pending},    8'h02);
    chk("rep_svc",  {7'h0, bus.in_service}, 8'h01);
    chk("rep_noie", {4'h0, ie_vec()},       8'h00);
    bus.irq = 4'b0000;
    pulse_eoi();
    step();
    chk("rep_reissue", {4'h0, ie_vec()},   8'h02);
    chk("rep_id",      {6'h0, bus.isr_id}, 8'h01);

    // Strobe on line 1 coincident with the ack of line 1: set wins
    step(); step();
    bus.irq = 4'b0010;   // s1 at next edge k, strobe sampled at k+2
    step();
    step();
    pulse_ack();         // ack sampled at edge k+2
    chk("simul_pend", {4'h0, bus.pending},    8'h02);
    chk("simul_ie",   {4'h0, ie_vec()},       8'h00);
    chk("simul_svc",  {7'h0, bus.in_service}, 8'h01);
    pulse_eoi();
    step();
    chk("simul_reissue", {4'h0, ie_vec()}, 8'h02);
    pulse_ack();
    pulse_eoi();

    // Reset mid-REQ with ie1 high
    bus.irq = 4'b0001;
    step(); step(); step(); step();
    chk("mid_ie", {4'h0, ie_vec()}, 8'h01);
    bus.irq = 4'b0000;
    reset   = 1'b1;
    step();
    reset   = 1'b0;
    chk("mid_rst_ie",   {4'h0, ie_vec()},       8'h00);
    chk("mid_rst_pend", {4'h0, bus.pending},    8'h00);
    chk("mid_rst_svc",  {7'h0, bus.in_service}, 8'h00);
    pulse_ack();
    chk("mid_ack_ie",   {4'h0, ie_vec()},       8'h00);
    chk("mid_ack_svc",  {7'h0, bus.in_service}, 8'h00);
    chk("mid_ack_pend", {4'h0, bus.pending},    8'h00);
    step();
    chk("mid_ack_svc2", {7'h0, bus.in_service}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
